// File: rtl/pwm_fade_ctrl_pkg.sv
// Shared constants for the PWM fade controller: FSM encoding and queue depth.
package pwm_fade_ctrl_pkg;

    localparam int FIFO_DEPTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RAMP = 2'd2,
        S_DONE = 2'd3
    } fade_state_t;

endpackage

// File: rtl/pwm_fade_ctrl_pwm.sv
// Single-channel PWM comparator: output is high while compare > shared counter.
module pwm_fade_ctrl_pwm #(
    parameter int CTR_LEN = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [CTR_LEN-1:0] i_count,
    input  logic [CTR_LEN-1:0] i_compare,
    output logic               o_pwm
);

    logic r_pwm;

    // Registered compare; a compare value of 0 can never exceed the counter.
    always_ff @(posedge clk) begin
        if (rst) r_pwm <= 1'b0;
        else     r_pwm <= (i_compare > i_count);
    end

    assign o_pwm = r_pwm;

endmodule

// File: rtl/pwm_fade_ctrl.sv
// Queued brightness fade controller driving one PWM output per channel.
module pwm_fade_ctrl
    import pwm_fade_ctrl_pkg::*;
#(
    parameter int CHANNELS   = 8,
    parameter int CTR_LEN    = 8,
    parameter int DIV_LEN    = 16,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [$clog2(CHANNELS)-1:0]   cmd_channel,
    input  logic [CTR_LEN-1:0]            cmd_target,
    input  logic [DIV_LEN-1:0]            cmd_div,
    input  logic                          abort,
    output logic                          busy,
    output logic                          done,
    output logic [$clog2(CHANNELS)-1:0]   done_channel,
    output logic [CHANNELS*CTR_LEN-1:0]   levels,
    output logic [CHANNELS-1:0]           pwm_out
);

    localparam int CH_W = $clog2(CHANNELS);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam logic [CTR_LEN-1:0] ONE = 1;

    // Command queue storage; pointers carry one extra bit to tell full from empty.
    logic [CH_W-1:0]    r_fifo_ch  [FIFO_DEPTH];
    logic [CTR_LEN-1:0] r_fifo_tgt [FIFO_DEPTH];
    logic [DIV_LEN-1:0] r_fifo_div [FIFO_DEPTH];
    logic [AW:0]        r_wr_ptr, r_rd_ptr;

    fade_state_t        r_state;
    logic [CH_W-1:0]    r_act_ch;
    logic [CTR_LEN-1:0] r_act_tgt;
    logic [DIV_LEN-1:0] r_act_div;
    logic [DIV_LEN-1:0] r_pre;
    logic               r_done;
    logic [CH_W-1:0]    r_done_ch;
    logic [CTR_LEN-1:0] r_levels [CHANNELS];
    logic [CTR_LEN-1:0] r_pwm_cnt;

    logic               w_empty, w_full, w_push, w_pop;
    logic [CTR_LEN-1:0] w_cur_level, w_next_level;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    // Readiness comes from registered pointers only, so a same-cycle pop
    // never opens a slot in a full queue. Abort discards any offered command.
    assign w_push  = cmd_valid && !w_full && !abort;
    assign w_pop   = (r_state == S_IDLE) && !w_empty && !abort;

    assign w_cur_level  = r_levels[r_act_ch];
    assign w_next_level = (w_cur_level < r_act_tgt) ? (w_cur_level + ONE)
                                                    : (w_cur_level - ONE);

    // Queue pointer bookkeeping; abort and reset both flush.
    always_ff @(posedge clk) begin
        if (rst || abort) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Queue payload write; contents are meaningless until the pointer advances.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_ch[r_wr_ptr[AW-1:0]]  <= cmd_channel;
            r_fifo_tgt[r_wr_ptr[AW-1:0]] <= cmd_target;
            r_fifo_div[r_wr_ptr[AW-1:0]] <= cmd_div;
        end
    end

    // Fade sequencer: pop, load, step the active level at the prescaled rate, report.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_act_ch  <= '0;
            r_act_tgt <= '0;
            r_act_div <= '0;
            r_pre     <= '0;
            r_done    <= 1'b0;
            r_done_ch <= '0;
            for (int i = 0; i < CHANNELS; i++) r_levels[i] <= '0;
        end else if (abort) begin
            r_state <= S_IDLE;
            r_pre   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        r_act_ch  <= r_fifo_ch[r_rd_ptr[AW-1:0]];
                        r_act_tgt <= r_fifo_tgt[r_rd_ptr[AW-1:0]];
                        r_act_div <= r_fifo_div[r_rd_ptr[AW-1:0]];
                        r_state   <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_pre <= '0;
                    if (w_cur_level == r_act_tgt) begin
                        r_state   <= S_DONE;
                        r_done    <= 1'b1;
                        r_done_ch <= r_act_ch;
                    end else begin
                        r_state <= S_RAMP;
                    end
                end
                S_RAMP: begin
                    if (r_pre == r_act_div) begin
                        r_pre              <= '0;
                        r_levels[r_act_ch] <= w_next_level;
                        // Leave on the same edge that lands on target, so an
                        // N-step fade spends exactly N prescaled periods in RAMP.
                        if (w_next_level == r_act_tgt) begin
                            r_state   <= S_DONE;
                            r_done    <= 1'b1;
                            r_done_ch <= r_act_ch;
                        end
                    end else begin
                        r_pre <= r_pre + 1'b1;
                    end
                end
                S_DONE: r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Free-running counter shared by every channel's comparator.
    always_ff @(posedge clk) begin
        if (rst) r_pwm_cnt <= '0;
        else     r_pwm_cnt <= r_pwm_cnt + ONE;
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        assign levels[g*CTR_LEN +: CTR_LEN] = r_levels[g];

        pwm_fade_ctrl_pwm #(.CTR_LEN(CTR_LEN)) u_pwm (
            .clk       (clk),
            .rst       (rst),
            .i_count   (r_pwm_cnt),
            .i_compare (r_levels[g]),
            .o_pwm     (pwm_out[g])
        );
    end

    assign cmd_ready    = !w_full;
    assign busy         = (r_state != S_IDLE) || !w_empty;
    assign done         = r_done;
    assign done_channel = r_done_ch;

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Directed bench for pwm_fade_ctrl with hand-computed timelines.
module tb_pwm_fade_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_channel = '0;
    logic [7:0]  cmd_target = '0;
    logic [15:0] cmd_div = '0;
    logic        abort = 1'b0;
    logic        busy, done;
    logic [2:0]  done_channel;
    logic [63:0] levels;
    logic [7:0]  pwm_out;

    int total = 0;
    int bad   = 0;

    pwm_fade_ctrl dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_channel(cmd_channel), .cmd_target(cmd_target), .cmd_div(cmd_div),
        .abort(abort), .busy(busy), .done(done), .done_channel(done_channel),
        .levels(levels), .pwm_out(pwm_out)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] lvl(input int c);
        return levels[c*8 +: 8];
    endfunction

    // Advance one edge; stimulus and sampling both happen 1ns after it.
    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Offer one command and return just after the edge that accepts it.
    task automatic send(input int ch, input int tgt, input int dv);
        int n = 0;
        cmd_channel = 3'(ch); cmd_target = 8'(tgt); cmd_div = 16'(dv);
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 200) begin tick(); n++; end
        total++;
        if (!cmd_ready) begin
            bad++;
            $display("FAIL send_timeout: cmd_ready=%0b required 1", cmd_ready);
        end
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!done && n < budget) begin tick(); n++; end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL wait_done_timeout: done=%0b required 1", done);
        end
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        total++; if (levels !== 64'd0) begin bad++; $display("FAIL rst_levels: got %h required 0", levels); end
        total++; if (pwm_out !== 8'd0) begin bad++; $display("FAIL rst_pwm: got %h required 0", pwm_out); end
        total++; if (busy !== 1'b0 || done !== 1'b0 || done_channel !== 3'd0) begin
            bad++; $display("FAIL rst_ctrl: busy=%0b done=%0b dch=%0d required 0/0/0", busy, done, done_channel); end
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %0b required 1", cmd_ready); end
        rst = 1'b0;
    endtask

    task automatic test_div0();
        send(2, 3, 0);                       // accepted at E0
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL div0_busy: got %0b required 1", busy); end
        tick(); tick();                      // E1 LOAD, E2 RAMP
        total++; if (lvl(2) !== 8'd0) begin bad++; $display("FAIL div0_l0: got %0d required 0", lvl(2)); end
        for (int k = 1; k <= 3; k++) begin
            tick();
            total++; if (lvl(2) !== 8'(k)) begin bad++; $display("FAIL div0_step%0d: got %0d required %0d", k, lvl(2), k); end
            total++; if (done !== (k == 3)) begin bad++; $display("FAIL div0_done%0d: got %0b required %0b", k, done, k == 3); end
        end
        total++; if (done_channel !== 3'd2) begin bad++; $display("FAIL div0_dch: got %0d required 2", done_channel); end
        total++; if (levels !== 64'h0000_0000_0003_0000) begin bad++; $display("FAIL div0_others: got %h required 0000000000030000", levels); end
        tick();
        total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL div0_end: done=%0b busy=%0b required 0/0", done, busy); end
    endtask

    task automatic test_slow_down();
        logic [7:0] exp;
        send(0, 10, 0);
        wait_done(100);
        total++; if (lvl(0) !== 8'd10) begin bad++; $display("FAIL slow_pre: got %0d required 10", lvl(0)); end
        send(0, 7, 4);                       // E0; RAMP starts E2, steps at E7, E12, E17
        for (int k = 1; k <= 18; k++) begin
            tick();
            exp = (k < 7) ? 8'd10 : (k < 12) ? 8'd9 : (k < 17) ? 8'd8 : 8'd7;
            total++; if (lvl(0) !== exp) begin bad++; $display("FAIL slow_lvl_e%0d: got %0d required %0d", k, lvl(0), exp); end
            total++; if (done !== (k == 17)) begin bad++; $display("FAIL slow_done_e%0d: got %0b required %0b", k, done, k == 17); end
        end
    endtask

    task automatic test_back_to_back();
        int chs [5] = '{6, 7, 6, 7, 4};
        int tgs [5] = '{2, 2, 0, 1, 1};
        int got = 0;
        int n = 0;
        for (int i = 0; i < 5; i++) begin
            cmd_channel = 3'(chs[i]); cmd_target = 8'(tgs[i]); cmd_div = 16'd3;
            cmd_valid = 1'b1;
            total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready%0d: got %0b required 1", i, cmd_ready); end
            tick();
        end
        cmd_valid = 1'b0;
        total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL b2b_full: got %0b required 0", cmd_ready); end
        while (got < 5 && n < 600) begin
            if (done) begin
                total++; if (done_channel !== 3'(chs[got])) begin
                    bad++; $display("FAIL b2b_order%0d: got ch %0d required %0d", got, done_channel, chs[got]); end
                got++;
            end
            tick(); n++;
        end
        total++; if (got != 5) begin bad++; $display("FAIL b2b_count: got %0d required 5", got); end
        total++; if (lvl(6) !== 8'd0 || lvl(7) !== 8'd1 || lvl(4) !== 8'd1) begin
            bad++; $display("FAIL b2b_levels: ch6=%0d ch7=%0d ch4=%0d required 0/1/1", lvl(6), lvl(7), lvl(4)); end
    endtask

    task automatic test_equal();
        send(1, 0, 0);                       // E0
        tick();                              // E1 LOAD
        total++; if (done !== 1'b0) begin bad++; $display("FAIL eq_early: got %0b required 0", done); end
        tick();                              // E2 DONE
        total++; if (done !== 1'b1 || done_channel !== 3'd1) begin
            bad++; $display("FAIL eq_done: done=%0b dch=%0d required 1/1", done, done_channel); end
        total++; if (lvl(1) !== 8'd0) begin bad++; $display("FAIL eq_level: got %0d required 0", lvl(1)); end
        tick();
        total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL eq_end: done=%0b busy=%0b required 0/0", done, busy); end
    endtask

    task automatic test_abort();
        int seen = 0;
        send(3, 100, 0);                     // E0, level 40 at E42
        send(5, 9, 0);                       // E1
        send(6, 9, 0);                       // E2
        for (int k = 0; k < 40; k++) tick();
        total++; if (lvl(3) !== 8'd40) begin bad++; $display("FAIL abort_pre: got %0d required 40", lvl(3)); end
        abort = 1'b1;
        cmd_valid = 1'b1; cmd_channel = 3'd5; cmd_target = 8'd9; cmd_div = 16'd0;
        tick();
        abort = 1'b0; cmd_valid = 1'b0;
        total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL abort_next: busy=%0b done=%0b required 0/0", busy, done); end
        total++; if (lvl(3) !== 8'd40) begin bad++; $display("FAIL abort_hold: got %0d required 40", lvl(3)); end
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL abort_ready: got %0b required 1", cmd_ready); end
        for (int k = 0; k < 6; k++) begin
            tick();
            if (done || busy) seen++;
        end
        total++; if (seen != 0) begin bad++; $display("FAIL abort_quiet: %0d active cycles required 0", seen); end
        total++; if (lvl(3) !== 8'd40 || lvl(5) !== 8'd0 || lvl(6) !== 8'd0) begin
            bad++; $display("FAIL abort_levels: ch3=%0d ch5=%0d ch6=%0d required 40/0/0", lvl(3), lvl(5), lvl(6)); end
    endtask

    task automatic test_pwm();
        int hi5, hi0, seen;
        send(5, 64, 0);
        wait_done(200);
        tick(); tick();
        hi5 = 0; hi0 = 0;
        for (int k = 0; k < 256; k++) begin
            if (pwm_out[5]) hi5++;
            if (pwm_out[0]) hi0++;
            tick();
        end
        total++; if (hi5 != 64) begin bad++; $display("FAIL pwm_64: got %0d high required 64", hi5); end
        total++; if (hi0 != 7) begin bad++; $display("FAIL pwm_ch0_7: got %0d high required 7", hi0); end
        send(5, 255, 0);
        wait_done(400);
        tick(); tick();
        hi5 = 0;
        for (int k = 0; k < 256; k++) begin
            if (pwm_out[5]) hi5++;
            tick();
        end
        total++; if (hi5 != 255) begin bad++; $display("FAIL pwm_255: got %0d high required 255", hi5); end
        send(5, 0, 2);
        for (int k = 0; k < 20; k++) tick();
        total++; if (lvl(5) == 8'd255 || lvl(5) == 8'd0) begin bad++; $display("FAIL rst_mid_pre: ch5=%0d required mid-fade", lvl(5)); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (levels !== 64'd0 || busy !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL rst_mid: levels=%h busy=%0b done=%0b required 0/0/0", levels, busy, done); end
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (pwm_out != 8'd0 || done) seen++;
        end
        total++; if (seen != 0) begin bad++; $display("FAIL rst_mid_quiet: %0d active cycles required 0", seen); end
    endtask

    initial begin
        test_reset();
        test_div0();
        test_slow_down();
        test_back_to_back();
        test_equal();
        test_abort();
        test_pwm();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pwm_fade_ctrl.md
PWM_FADE_CTRL -- requirements
Module: pwm_fade_ctrl

Interface
REQ-001 SHALL have parameter CHANNELS, default 8, number of PWM outputs.
REQ-002 SHALL have parameter CTR_LEN, default 8, width of each brightness level and PWM counter.
REQ-003 SHALL have parameter DIV_LEN, default 16, width of the per-command step divider.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, command queue depth (power of two).
REQ-005 SHALL have port clk, input, 1, single system clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port cmd_valid, input, 1, command offered.
REQ-008 SHALL have port cmd_ready, output, 1, command queue can accept.
REQ-009 SHALL have port cmd_channel, input, clog2(CHANNELS), target channel index.
REQ-010 SHALL have port cmd_target, input, CTR_LEN, final brightness level.
REQ-011 SHALL have port cmd_div, input, DIV_LEN, step period minus one, in clk cycles.
REQ-012 SHALL have port abort, input, 1, flush queue and stop the active fade.
REQ-013 SHALL have port busy, output, 1, fade active or queue non-empty.
REQ-014 SHALL have port done, output, 1, one-cycle pulse at fade completion.
REQ-015 SHALL have port done_channel, output, clog2(CHANNELS), channel of the completed fade; valid with done.
REQ-016 SHALL have port levels, output, CHANNELS*CTR_LEN, current level of every channel; channel i at bits [i*CTR_LEN +: CTR_LEN].
REQ-017 SHALL have port pwm_out, output, CHANNELS, PWM waveform per channel.

Function
REQ-018 Command SHALL be accepted on a cycle where cmd_valid && cmd_ready; cmd_ready = queue not full; a pop in the same cycle SHALL NOT make a full queue ready.
REQ-019 Queue SHALL be FIFO ordered; accepted commands are never dropped except by abort or rst.
REQ-020 FSM states SHALL be IDLE, LOAD, RAMP, DONE.
REQ-021 IDLE: if queue non-empty, pop head -> LOAD; else remain.
REQ-022 LOAD: latch channel/target/div, clear prescaler; level == target -> DONE, else -> RAMP.
REQ-023 RAMP: prescaler counts 0..div; on the cycle it equals div, it SHALL wrap to 0 and the active level SHALL move one step toward target (+1 or -1, never overshoot, no wrap at 0 or 2^CTR_LEN-1).
REQ-024 RAMP -> DONE on the cycle after the level equals target.
REQ-025 DONE: done=1 and done_channel=latched channel for exactly one cycle -> IDLE.
REQ-026 Only the active channel's level SHALL change; other levels hold.
REQ-027 With div=0, the level SHALL change every RAMP cycle; fade of N steps SHALL take N RAMP cycles.
REQ-028 abort SHALL, on the next edge, empty the queue, force IDLE, emit no done, leave all levels at current values; abort overrides a simultaneous command acceptance (command discarded).
REQ-029 busy SHALL be 1 whenever state != IDLE or queue non-empty.
REQ-030 pwm_out[i] SHALL be high while level_i > free-running CTR_LEN counter; level 0 = always low.

Reset
REQ-031 rst SHALL set: all levels 0, queue empty, state IDLE, prescaler 0, done 0, done_channel 0, busy 0, pwm_out 0, cmd_ready 1 on the cycle after reset.
REQ-032 rst mid-fade SHALL discard the active and queued commands with no done pulse.

Structure
REQ-033 FSM state encoding and FIFO_DEPTH default SHALL live in the shared project constants file.
REQ-034 Each channel's waveform SHALL be generated by one instance of the existing pwm sub-module (CTR_LEN passed through, compare = level_i); controller logic SHALL NOT duplicate the PWM comparator.

Verification
REQ-035 Reset, ch2 target 3 div 0 -> levels ch2 steps 1,2,3 on consecutive cycles, one done pulse with done_channel=2, busy falls after DONE.
REQ-036 ch0 at 10, target 7 div 4 -> level decrements every 5 cycles, 7 reached after 15 RAMP cycles, no undershoot.
REQ-037 Push 5 commands back-to-back with cmd_valid held -> cmd_ready low after 4 (with 1 popped, per timing), all accepted commands complete in order, 5 done pulses.
REQ-038 Command target equal to current level (ch1 0 -> 0) -> LOAD then DONE, done pulse, level unchanged.
REQ-039 Abort during ch3 ramp at level 40 with 2 queued -> IDLE next cycle, ch3 holds 40, no done, busy 0, queue empty.
REQ-040 ch5 level 64 -> pwm_out[5] high 64 of every 256 cycles; ch5 level 255 -> high 255 of 256; rst mid-fade -> all levels 0, pwm_out 0.
